dlx_encoder: RTL and testbench
==============================

# dlx_encoder

Instruction encoder and program writer for the DLX core: accepts one decoded instruction per handshake (operation kind, ALU code, register numbers, immediate), packs it into a 32-bit DLX instruction word, and writes it to instruction memory at consecutive word addresses. It is the inverse of the instruction decoder and shares its ALU code numbering (`I`). It sits between a test/boot sequencer and the instruction memory write port.

## Interface
- `DEPTH`, 1024: words written per program load before the block stops accepting.
- `BASE_ADDR`, 32'h0: byte address of the first written word.
- `clk` input 1: clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: begin a load; honoured only in IDLE or FULL.
- `in_valid` input 1: instruction fields are valid.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_kind` input 3: 0 ALU reg, 1 ALU imm, 2 LW, 3 SW, 4 BEQZ, 5 BNEZ, 6 J/JAL, 7 JR/JALR.
- `in_link` input 1: selects JAL/JALR for kinds 6/7.
- `in_I` input 4: ALU code, same numbering as the decoder.
- `in_rs1`, `in_rs2`, `in_rd` input 5 each: register numbers.
- `in_imm` input 32: signed immediate or jump offset.
- `i_write_enable` output 1: instruction memory write strobe.
- `i_address` output 32: byte address of the write.
- `i_data_write` output 32: encoded instruction.
- `done` output 1: one-cycle pulse with the last write of a load.
- `err` output 1: one-cycle pulse with a write whose fields were illegal.
- `err_count` output 16: saturating count of `err` pulses since `start`.

## Operation
- States: IDLE, RUN, FULL. Reset goes to IDLE. `start` in IDLE/FULL clears the word counter `n` and `err_count` and enters RUN. `start` in RUN is ignored.
- `in_ready` = 1 only in RUN. A beat is accepted when `in_valid && in_ready`.
- Accepted beat n is written at `BASE_ADDR + 4*n` and `n` increments. The beat with n = DEPTH-1 moves the state to FULL.
- R-type (kind 0): [31:26]=0, [25:21]=rs1, [20:16]=rs2, [15:11]=rd, [10:6]=0, [5:0]=func.
  - func values: I=1→20h, 2→22h, 3→24h, 4→25h, 5→26h, 6→04h, 7→06h, 10→28h, 11→2Ch, 12→2Ah, 13→29h, 14→07h.
- Immediate ALU (kind 1): [31:26]=op, [25:21]=rs1, [20:16]=rd, [15:0]=imm[15:0].
  - op values: I=0→0Fh (LHI), 1→08h, 2→0Ah, 3→0Ch, 4→0Dh, 5→0Eh, 6→14h, 7→16h, 10→18h, 11→1Ch, 12→1Ah, 13→19h, 14→17h.
- LW: op 23h, rs1=base, [20:16]=rd. SW: op 2Bh, rs1=base, [20:16]=rs2. Both use imm[15:0].
- BEQZ 04h / BNEZ 05h: rs1, [20:16]=0, imm[15:0].
- J 02h / JAL 03h: [25:0]=imm[25:0].
- JR 12h / JALR 13h: rs1, [20:0]=0.
- Illegal fields (word still written, `err` pulsed):
  - unlisted `in_I` for kind 0/1 (encode as all zero word);
  - 16-bit immediate not sign-representable (imm[31:15] not uniform);
  - shift immediate (I=6,7,14) outside 0..31;
  - LHI imm outside 0..FFFFh unsigned;
  - J/JAL imm[31:25] not uniform.
- `err_count` saturates at FFFFh.

## Timing
- Reset values: `in_ready`=0, `i_write_enable`=0, `i_address`=0, `i_data_write`=0, `done`=0, `err`=0, `err_count`=0, state IDLE, n=0.
- Latency 1: beat accepted in cycle t gives `i_write_enable`=1 with address/data/`err` in cycle t+1. Full throughput, one write per cycle.
- `done` is asserted in the same cycle as the write of beat DEPTH-1. `in_ready` is 0 from the cycle after that beat was accepted.
- `start` in FULL while the last write is being issued: the write completes, and the next load starts at n=0.
- Reset during RUN drops any pending write. No write strobe appears on the cycle after reset.

## Test plan
- Reset, `start`, kind0 I=1 rs1=1 rs2=2 rd=3 → write 00221820h at `BASE_ADDR`, `err`=0.
- kind1 I=1 rs1=1 rd=5 imm=-4 → 2025FFFCh. Next kind3 rs1=2 rs2=7 imm=8 → AC470008h at +4.
- kind6 link=1 imm=100h → 0C000100h. kind7 link=0 rs1=31 → 4BE00000h.
- kind1 I=1 imm=12345h → word 20..2345h with `err`=1, `err_count`=1. kind0 I=9 → 0, `err`.
- DEPTH=4 with `in_valid` held high: writes at +0..+12, `done` on the 4th write, `in_ready` low afterwards. `start` in FULL resumes at `BASE_ADDR`.
- Assert reset in mid-stream with a beat just accepted → no write next cycle, all outputs at reset values.

Source files
------------

// File: rtl/dlx_encoder.sv
// DLX instruction encoder and program writer.
// Packs decoded fields into DLX words and streams them into instruction memory.
module dlx_encoder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic        in_link,
  input  logic [3:0]  in_I,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        i_write_enable,
  output logic [31:0] i_address,
  output logic [31:0] i_data_write,
  output logic        done,
  output logic        err,
  output logic [15:0] err_count
);

  localparam int NW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [5:0]  func, op;
  logic        func_ok, op_ok;
  logic        imm16_ok, j_ok, shift;
  logic [31:0] word;
  logic        bad;
  logic        accept, last;

  assign in_ready = (state_q == S_RUN);
  assign accept   = in_valid && in_ready;
  assign last     = (n_q == NW'(DEPTH - 1));
  assign imm16_ok = (&in_imm[31:15]) | ~(|in_imm[31:15]);
  assign j_ok     = (&in_imm[31:25]) | ~(|in_imm[31:25]);
  assign shift    = (in_I == 4'd6) || (in_I == 4'd7) || (in_I == 4'd14);

  always_comb begin
    func    = 6'h00;
    op      = 6'h00;
    func_ok = 1'b1;
    op_ok   = 1'b1;
    case (in_I)
      4'd0:  begin op = 6'h0F; func_ok = 1'b0; end
      4'd1:  begin func = 6'h20; op = 6'h08; end
      4'd2:  begin func = 6'h22; op = 6'h0A; end
      4'd3:  begin func = 6'h24; op = 6'h0C; end
      4'd4:  begin func = 6'h25; op = 6'h0D; end
      4'd5:  begin func = 6'h26; op = 6'h0E; end
      4'd6:  begin func = 6'h04; op = 6'h14; end
      4'd7:  begin func = 6'h06; op = 6'h16; end
      4'd10: begin func = 6'h28; op = 6'h18; end
      4'd11: begin func = 6'h2C; op = 6'h1C; end
      4'd12: begin func = 6'h2A; op = 6'h1A; end
      4'd13: begin func = 6'h29; op = 6'h19; end
      4'd14: begin func = 6'h07; op = 6'h17; end
      default: begin func_ok = 1'b0; op_ok = 1'b0; end
    endcase
  end

  always_comb begin
    word = 32'h0;
    bad  = 1'b0;
    case (in_kind)
      3'd0: begin
        if (func_ok)
          word = {6'h00, in_rs1, in_rs2, in_rd, 5'h00, func};
        else
          bad = 1'b1;
      end
      3'd1: begin
        if (!op_ok) begin
          bad = 1'b1;
        end else begin
          word = {op, in_rs1, in_rd, in_imm[15:0]};
          // LHI takes a raw 16-bit value, shifts take an amount
          if (in_I == 4'd0)
            bad = |in_imm[31:16];
          else if (shift)
            bad = |in_imm[31:5];
          else
            bad = !imm16_ok;
        end
      end
      3'd2: begin
        word = {6'h23, in_rs1, in_rd, in_imm[15:0]};
        bad  = !imm16_ok;
      end
      3'd3: begin
        word = {6'h2B, in_rs1, in_rs2, in_imm[15:0]};
        bad  = !imm16_ok;
      end
      3'd4, 3'd5: begin
        word = {5'h02, in_kind[0], in_rs1, 5'h00, in_imm[15:0]};
        bad  = !imm16_ok;
      end
      3'd6: begin
        word = {5'h01, in_link, in_imm[25:0]};
        bad  = !j_ok;
      end
      default: begin
        word = {5'h09, in_link, in_rs1, 21'h0};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    we_d    = accept;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = accept && bad;
    done_d  = accept && last;
    if (accept) begin
      addr_d = BASE_ADDR + (32'(n_q) << 2);
      data_d = word;
      n_d    = n_q + NW'(1);
      if (bad && cnt_q != 16'hFFFF)
        cnt_d = cnt_q + 16'd1;
      if (last)
        state_d = S_FULL;
    end
    if (start && state_q != S_RUN) begin
      state_d = S_RUN;
      n_d     = '0;
      cnt_d   = 16'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i_write_enable = we_q;
  assign i_address      = addr_q;
  assign i_data_write   = data_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_count      = cnt_q;

endmodule

// File: tb/tb_dlx_encoder.sv
// Directed bench for dlx_encoder, DEPTH=4 at base 1000h.
module tb_dlx_encoder;

  localparam logic [31:0] BASE = 32'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic        in_link;
  logic [3:0]  in_I;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        i_write_enable;
  logic [31:0] i_address;
  logic [31:0] i_data_write;
  logic        done;
  logic        err;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  dlx_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_link(in_link), .in_I(in_I),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm),
    .i_write_enable(i_write_enable), .i_address(i_address),
    .i_data_write(i_data_write), .done(done), .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic e,
                        input logic dn, input logic [15:0] c);
    chk({tag, ".we"}, 32'(i_write_enable), 32'd1);
    chk({tag, ".addr"}, i_address, a);
    chk({tag, ".data"}, i_data_write, d);
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".cnt"}, 32'(err_count), 32'(c));
  endtask

  task automatic drive(input logic [2:0] k, input logic l,
                       input logic [3:0] i, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d,
                       input logic [31:0] imm);
    in_valid = 1'b1;
    in_kind  = k;
    in_link  = l;
    in_I     = i;
    in_rs1   = s1;
    in_rs2   = s2;
    in_rd    = d;
    in_imm   = imm;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".we"}, 32'(i_write_enable), 32'd0);
    chk({tag, ".addr"}, i_address, 32'h0);
    chk({tag, ".data"}, i_data_write, 32'h0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".cnt"}, 32'(err_count), 32'd0);
    chk({tag, ".rdy"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_kind = '0; in_link = 1'b0; in_I = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;

    // load 1: legal words, full throughput
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("l1.rdy", 32'(in_ready), 32'd1);
    drive(3'd0, 1'b0, 4'd1, 5'd1, 5'd2, 5'd3, 32'h0);
    @(negedge clk);
    chk_wr("l1.add", BASE, 32'h00221820, 1'b0, 1'b0, 16'd0);
    drive(3'd1, 1'b0, 4'd1, 5'd1, 5'd0, 5'd5, 32'hFFFF_FFFC);
    @(negedge clk);
    chk_wr("l1.addi", BASE + 4, 32'h2025FFFC, 1'b0, 1'b0, 16'd0);
    drive(3'd3, 1'b0, 4'd0, 5'd2, 5'd7, 5'd0, 32'h8);
    @(negedge clk);
    chk_wr("l1.sw", BASE + 8, 32'hAC470008, 1'b0, 1'b0, 16'd0);
    drive(3'd6, 1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 32'h100);
    @(negedge clk);
    in_valid = 1'b0;
    chk_wr("l1.jal", BASE + 12, 32'h0C000100, 1'b0, 1'b1, 16'd0);
    chk("l1.rdy_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("l1.idle_we", 32'(i_write_enable), 32'd0);
    chk("l1.idle_done", 32'(done), 32'd0);

    // load 2: illegal fields and error counting
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("l2.rdy", 32'(in_ready), 32'd1);
    drive(3'd7, 1'b0, 4'd0, 5'd31, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    chk_wr("l2.jr", BASE, 32'h4BE00000, 1'b0, 1'b0, 16'd0);
    drive(3'd1, 1'b0, 4'd1, 5'd1, 5'd0, 5'd5, 32'h12345);
    @(negedge clk);
    chk_wr("l2.bigimm", BASE + 4, 32'h20252345, 1'b1, 1'b0, 16'd1);
    drive(3'd0, 1'b0, 4'd9, 5'd1, 5'd2, 5'd3, 32'h0);
    @(negedge clk);
    chk_wr("l2.badI", BASE + 8, 32'h0, 1'b1, 1'b0, 16'd2);
    drive(3'd1, 1'b0, 4'd6, 5'd2, 5'd0, 5'd3, 32'd32);
    @(negedge clk);
    in_valid = 1'b0;
    chk_wr("l2.shamt", BASE + 12, 32'h50430020, 1'b1, 1'b1, 16'd3);
    start = 1'b1;

    // load 3: restart from FULL during last write, valid held high
    @(negedge clk); start = 1'b0;
    chk("l3.rdy", 32'(in_ready), 32'd1);
    chk("l3.we0", 32'(i_write_enable), 32'd0);
    chk("l3.cnt0", 32'(err_count), 32'd0);
    drive(3'd1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_wr($sformatf("l3.w%0d", k), BASE + 32'(4 * k),
             32'h3C01FFFF, 1'b0, (k == 3), 16'd0);
    end
    chk("l3.rdy_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("l3.no_more", 32'(i_write_enable), 32'd0);
    in_valid = 1'b0;

    // load 4: reset mid-stream drops the pending beat
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    drive(3'd2, 1'b0, 4'd0, 5'd4, 5'd0, 5'd6, 32'hFFFF_FFF0);
    @(negedge clk);
    chk_wr("l4.lw", BASE, 32'h8C86FFF0, 1'b0, 1'b0, 16'd0);
    drive(3'd4, 1'b0, 4'd0, 5'd9, 5'd0, 5'd0, 32'h10);
    @(negedge clk);
    chk_wr("l4.beqz", BASE + 4, 32'h11200010, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_reset("l4.rst");
    reset = 1'b0;
    @(negedge clk);
    chk_reset("l4.post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
